// File: rtl/axil_wb_rdwr_arbiter.sv
// Arbitrates one pipelined Wishbone slave between an AXI-lite read bridge (A) and write bridge (B).
// Optional ack timeout enabled by defining WB_RDWR_ARB_TIMEOUT_EN.
module axil_wb_rdwr_arbiter #(
  parameter int AW        = 26,
  parameter int DW        = 32,
  parameter int LGMAXOUT  = 3,
  parameter int LGTIMEOUT = 10
) (
  input  logic              i_clk,
  input  logic              i_axi_reset_n,
  // read master
  input  logic              i_a_cyc,
  input  logic              i_a_stb,
  input  logic [AW-1:0]     i_a_addr,
  output logic              o_a_stall,
  output logic              o_a_ack,
  output logic              o_a_err,
  output logic [DW-1:0]     o_a_data,
  // write master
  input  logic              i_b_cyc,
  input  logic              i_b_stb,
  input  logic [AW-1:0]     i_b_addr,
  input  logic [DW-1:0]     i_b_data,
  input  logic [DW/8-1:0]   i_b_sel,
  output logic              o_b_stall,
  output logic              o_b_ack,
  output logic              o_b_err,
  // shared slave bus
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [AW-1:0]     o_wb_addr,
  output logic [DW-1:0]     o_wb_data,
  output logic [DW/8-1:0]   o_wb_sel,
  input  logic              i_wb_stall,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [DW-1:0]     i_wb_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [LGMAXOUT:0] MAXOUT  = {1'b1, {LGMAXOUT{1'b0}}};
  localparam logic [LGMAXOUT:0] OUT_ONE = {{LGMAXOUT{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              last_owner_b_q, last_owner_b_d;
  logic [LGMAXOUT:0] outstanding_q;
  logic              cap_hit;
  logic              accept;
  logic              timeout;

  // An ack in the same cycle frees a slot, so it does not count toward the cap.
  assign cap_hit  = (outstanding_q == MAXOUT) && !i_wb_ack;
  assign accept   = o_wb_stb && !i_wb_stall;
  assign o_a_data = i_wb_data;

`ifdef WB_RDWR_ARB_TIMEOUT_EN
  localparam logic [LGTIMEOUT-1:0] TMR_MAX = '1;
  localparam logic [LGTIMEOUT-1:0] TMR_ONE = {{(LGTIMEOUT-1){1'b0}}, 1'b1};

  logic [LGTIMEOUT-1:0] timer_q;

  assign timeout = (state_q != IDLE) && (timer_q == TMR_MAX);

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      timer_q <= '0;
    end else if (timeout || i_wb_ack || i_wb_err || (outstanding_q == '0)) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_ONE;
    end
  end
`else
  logic unused_cfg;

  assign timeout    = 1'b0;
  assign unused_cfg = (LGTIMEOUT > 0);
`endif

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      state_q        <= IDLE;
      last_owner_b_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      last_owner_b_q <= last_owner_b_d;
    end
  end

  // Outstanding count; a bus error ends the transaction sequence and forgets everything in flight.
  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      outstanding_q <= '0;
    end else if (!o_wb_cyc || i_wb_err) begin
      outstanding_q <= '0;
    end else if (accept && !i_wb_ack) begin
      outstanding_q <= outstanding_q + OUT_ONE;
    end else if (!accept && i_wb_ack && (outstanding_q != '0)) begin
      outstanding_q <= outstanding_q - OUT_ONE;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_owner_b_d = last_owner_b_q;
    o_wb_cyc       = 1'b0;
    o_wb_stb       = 1'b0;
    o_wb_we        = 1'b0;
    o_wb_addr      = '0;
    o_wb_data      = '0;
    o_wb_sel       = '0;
    o_a_stall      = 1'b1;
    o_b_stall      = 1'b1;
    o_a_ack        = 1'b0;
    o_a_err        = 1'b0;
    o_b_ack        = 1'b0;
    o_b_err        = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_a_cyc && i_b_cyc) begin
          state_d = last_owner_b_q ? GRANT_A : GRANT_B;
        end else if (i_a_cyc) begin
          state_d = GRANT_A;
        end else if (i_b_cyc) begin
          state_d = GRANT_B;
        end
      end

      GRANT_A: begin
        o_wb_cyc  = i_a_cyc;
        o_wb_stb  = i_a_stb && !cap_hit;
        o_wb_addr = i_a_addr;
        o_wb_sel  = '1;
        o_a_stall = i_wb_stall || cap_hit;
        o_a_ack   = i_a_cyc && i_wb_ack;
        o_a_err   = i_a_cyc && (i_wb_err || timeout);
        if (!i_a_cyc || timeout) begin
          state_d        = IDLE;
          last_owner_b_d = 1'b0;
        end
      end

      GRANT_B: begin
        o_wb_cyc  = i_b_cyc;
        o_wb_stb  = i_b_stb && !cap_hit;
        o_wb_we   = 1'b1;
        o_wb_addr = i_b_addr;
        o_wb_data = i_b_data;
        o_wb_sel  = i_b_sel;
        o_b_stall = i_wb_stall || cap_hit;
        o_b_ack   = i_b_cyc && i_wb_ack;
        o_b_err   = i_b_cyc && (i_wb_err || timeout);
        if (!i_b_cyc || timeout) begin
          state_d        = IDLE;
          last_owner_b_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
